// File: rtl/unsat_clause_picker.sv
// unsat_clause_picker: drains the unsat-clause FIFO tree each round and reservoir-samples one clause.
// Optional UNSAT_PICK_STATS_EN adds count_o with the clauses captured in the last round.
module unsat_clause_picker #(
  parameter int CLAUSE_WIDTH = 36,
  parameter int CNT_W = 10,
  parameter int SETTLE_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    fill_done_i,
  input  logic                    fifo_empty_i,
  input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
  input  logic                    fifo_of_i,
  output logic                    fifo_rden_o,
  output logic                    fifo_cof_o,
  output logic [CLAUSE_WIDTH-1:0] clause_o,
  output logic                    done_o,
  output logic                    pick_valid_o,
  output logic                    none_o,
  output logic                    of_o,
  output logic                    busy_o
`ifdef UNSAT_PICK_STATS_EN
  ,
  output logic [CNT_W-1:0]        count_o
`endif
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2;
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam int QW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [QW-1:0] SETTLE = QW'(SETTLE_CYCLES);
  logic [1:0] state;
  logic [15:0] lfsr;
  logic [CNT_W-1:0] count, n, mask;
  logic [QW-1:0] quiet;
  logic [CLAUSE_WIDTH-1:0] cand;
  logic cap, fd, ofl, ofn, settled;
  assign busy_o = state == DRAIN;
  assign done_o = state == DONE;
  assign fifo_rden_o = busy_o & ~fifo_empty_i;
  assign fifo_cof_o = done_o & of_o;
  assign ofn = ofl | fifo_of_i;
  assign settled = quiet == SETTLE;
  // mask = 2^ceil(log2 n)-1, built by smearing the top set bit of n-1 downward
  always_comb begin
    n = &count ? count : count + CNT_W'(1);
    mask = n - CNT_W'(1);
    for (int i = 0; i < CNT_W; i++) mask = mask | (mask >> 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lfsr <= SEED;
      count <= '0;
      quiet <= '0;
      cand <= '0;
      cap <= 1'b0;
      fd <= 1'b0;
      ofl <= 1'b0;
      clause_o <= '0;
      pick_valid_o <= 1'b0;
      none_o <= 1'b0;
      of_o <= 1'b0;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      cap <= fifo_rden_o;
      if (state == IDLE && start_i) begin
        state <= DRAIN;
        pick_valid_o <= 1'b0;
        none_o <= 1'b0;
        of_o <= 1'b0;
        count <= '0;
        quiet <= '0;
        fd <= fill_done_i;
        ofl <= 1'b0;
      end else if (busy_o) begin
        fd <= fd | fill_done_i;
        ofl <= ofn;
        if (cap) begin
          count <= n;
          if ((lfsr[CNT_W-1:0] & mask) == '0) cand <= fifo_clause_i;
        end
        quiet <= (fifo_rden_o | cap | ~fifo_empty_i) ? '0 : (fd & ~settled) ? quiet + QW'(1) : quiet;
        if (settled) begin
          state <= DONE;
          of_o <= ofn;
          none_o <= ~ofn & (count == '0);
          pick_valid_o <= ~ofn & (count != '0);
          if (~ofn & (count != '0)) clause_o <= cand;
        end
      end else if (done_o) state <= IDLE;
    end
`ifdef UNSAT_PICK_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) count_o <= '0;
    else if (busy_o && settled) count_o <= count;
`endif
endmodule

// File: tb/tb_unsat_clause_picker.sv
// tb_unsat_clause_picker: randomized rounds against a FIFO-tree model and a reservoir-sampling reference.
module tb_unsat_clause_picker;
  localparam int CW = 36, CNT_W = 10, SETTLE = 8;
  localparam logic [15:0] SEED = 16'h0001;
  logic clk = 0, reset = 1, start_i = 0, fill_done_i = 0, fifo_empty_i = 1, fifo_of_i = 0;
  logic [CW-1:0] fifo_clause_i = '0;
  logic fifo_rden_o, fifo_cof_o, done_o, pick_valid_o, none_o, of_o, busy_o;
  logic [CW-1:0] clause_o;
`ifdef UNSAT_PICK_STATS_EN
  logic [CNT_W-1:0] count_o;
`endif
  unsat_clause_picker #(.CLAUSE_WIDTH(CW), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .fill_done_i(fill_done_i), .fifo_empty_i(fifo_empty_i),
    .fifo_clause_i(fifo_clause_i), .fifo_of_i(fifo_of_i), .fifo_rden_o(fifo_rden_o), .fifo_cof_o(fifo_cof_o),
    .clause_o(clause_o), .done_o(done_o), .pick_valid_o(pick_valid_o), .none_o(none_o), .of_o(of_o),
    .busy_o(busy_o)
`ifdef UNSAT_PICK_STATS_EN
    , .count_o(count_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct { bit none; bit of; bit pv; logic [CW-1:0] clause; int cnt; } exp_t;
  exp_t sb[$];
  logic [CW-1:0] tq[$];
  int checks = 0, passes = 0, cyc = 0;
  bit s_rden = 0, s_busy = 0, s_done = 0, m_pend = 0, m_of = 0;
  int m_cnt = 0, m_rd = 0;
  logic [15:0] m_lfsr;
  logic [CW-1:0] m_pick = '0, m_data = '0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    s_rden = fifo_rden_o;
    s_busy = busy_o;
    s_done = done_o;
  end
  // tree model plus reference: first clause always taken, clause k replaces with chance 1/2^ceil(log2 k)
  always @(posedge clk) begin
    int mk;
    if (reset) begin
      m_lfsr = SEED;
      m_pend = 0;
      m_cnt = 0;
      m_of = 0;
      m_rd = 0;
      tq.delete();
      #1 fifo_empty_i = 1;
    end else begin
      if (start_i && !s_busy && !s_done) begin
        m_cnt = 0;
        m_of = 0;
        m_rd = 0;
      end
      if (s_busy && fifo_of_i) m_of = 1;
      if (m_pend) begin
        m_cnt++;
        mk = (1 << $clog2(m_cnt)) - 1;
        if ((int'(m_lfsr) & mk) == 0) m_pick = m_data;
        m_pend = 0;
      end
      if (s_rden) begin
        m_rd++;
        m_data = tq.size() != 0 ? tq.pop_front() : '0;
        m_pend = 1;
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      #1;
      fifo_clause_i = m_data;
      fifo_empty_i = tq.size() == 0;
    end
  end
  always @(negedge clk) if (!reset) begin
    exp_t e;
    if (fifo_rden_o && !busy_o) begin
      checks++;
      $display("FAIL rden_outside_drain: got 1 expected 0");
    end
    if (fifo_cof_o && !done_o) begin
      checks++;
      $display("FAIL cof_outside_done: got 1 expected 0");
    end
    if (done_o) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done_o=1 expected no round end");
      end else begin
        e = sb.pop_front();
        check("of_o", of_o, e.of);
        check("none_o", none_o, e.none);
        check("pick_valid_o", pick_valid_o, e.pv);
        check("fifo_cof_o", fifo_cof_o, e.of);
        if (e.pv) check("clause_o", clause_o, e.clause);
`ifdef UNSAT_PICK_STATS_EN
        check("count_o", count_o, e.cnt);
`endif
      end
    end
  end
  task automatic wait_drained();
    int g = 0;
    while ((tq.size() != 0 || m_pend || !fifo_empty_i) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++;
      $display("FAIL drain_timeout: got %0d queued expected 0", tq.size());
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic run_round(int n, bit ovf, bit late, logic [CW-1:0] first, string tag);
    exp_t e;
    int t0, g;
    logic [CW-1:0] d;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = CW'({$urandom(), $urandom()});
      tq.push_back(i == 0 ? first : d);
      if (ovf && i == n / 2) fifo_of_i = 1;
      if (i == 1) begin
        start_i = 1;
        @(negedge clk);
        start_i = 0;
      end
    end
    if (n > 0) wait_drained();
    fill_done_i = 1;
    t0 = cyc;
    @(negedge clk);
    fill_done_i = 0;
    if (late) begin
      repeat (4) @(negedge clk);
      tq.push_back(CW'({$urandom(), $urandom()}));
      t0 = cyc;
      wait_drained();
    end
    e.of = m_of;
    e.none = !m_of && m_cnt == 0;
    e.pv = !m_of && m_cnt != 0;
    e.clause = m_pick;
    e.cnt = m_cnt;
    sb.push_back(e);
    g = 0;
    while (!done_o && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!done_o) begin
      checks++;
      $display("FAIL %s_done_timeout: got no done_o expected done_o", tag);
      sb.delete();
    end else check({tag, "_latency"}, cyc - t0, late ? SETTLE + 4 : SETTLE + 2);
    check({tag, "_reads"}, m_rd, n + int'(late));
    fifo_of_i = 0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no summary expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("reset_pick_valid", pick_valid_o, 0);
    check("reset_none", none_o, 0);
    check("reset_clause", clause_o, 0);
    check("reset_busy_rden", {busy_o, fifo_rden_o, done_o, of_o, fifo_cof_o}, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    run_round(0, 0, 0, '0, "empty");
    run_round(1, 0, 0, 36'h0_0000_0ABC, "single");
    run_round(5, 0, 0, CW'({$urandom(), $urandom()}), "five");
    run_round(3, 1, 0, CW'({$urandom(), $urandom()}), "overflow");
    run_round(2, 0, 1, CW'({$urandom(), $urandom()}), "late");
    repeat (8) run_round($urandom_range(0, 12), $urandom_range(0, 3) == 0, 0, CW'({$urandom(), $urandom()}), "rand");
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    repeat (4) tq.push_back(CW'({$urandom(), $urandom()}));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort_rden_busy", {fifo_rden_o, busy_o}, 0);
    check("abort_outputs", {done_o, pick_valid_o, none_o, of_o, fifo_cof_o}, 0);
    check("abort_clause", clause_o, 0);
`ifdef UNSAT_PICK_STATS_EN
    check("abort_count", count_o, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    run_round(4, 0, 0, CW'({$urandom(), $urandom()}), "post_reset");
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/unsat_clause_picker.md
Name: unsat_clause_picker

Overview:
- Consumer stage directly downstream of the FIFO tree that collects unsatisfied clauses each solver step.
- Drains every clause the tree emits in a round and picks one uniformly-ish at random (power-of-two reservoir sampling, LFSR driven) for the variable-flip stage.
- Reports "no unsat clause" (solution found) and tree overflow, and clears the tree's sticky OF flag.

Parameters:
- CLAUSE_WIDTH, 36, width of one clause word.
- CNT_W, 10, width of popped-clause counter; legal range 1..16.
- SETTLE_CYCLES, 8, consecutive quiet empty cycles needed to declare the tree drained; must be >= 1.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; begins a round. Ignored unless idle.
- fill_done_i  in  1  pulse/level; upstream has finished writing all clauses for this round.
- fifo_empty_i  in  1  tree empty flag.
- fifo_clause_i  in  CLAUSE_WIDTH  tree output data; valid one cycle after fifo_rden_o.
- fifo_of_i  in  1  tree sticky overflow flag.
- fifo_rden_o  out  1  tree read enable.
- fifo_cof_o  out  1  one-cycle pulse that clears the tree OF.
- clause_o  out  CLAUSE_WIDTH  selected clause, held until next start_i.
- done_o  out  1  one-cycle round-complete pulse.
- pick_valid_o  out  1  clause_o is valid (level, cleared at start_i).
- none_o  out  1  round ended with zero clauses and no overflow (level).
- of_o  out  1  round ended with overflow (level).
- busy_o  out  1  high in DRAIN.

Behaviour:
- Reset (async): state IDLE; all outputs 0; clause_o 0; counters 0; LFSR = seed.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle out of reset.
- States: IDLE -> DRAIN on start_i; DRAIN -> DONE when quiet count reaches SETTLE_CYCLES; DONE -> IDLE unconditionally after 1 cycle.
- On start_i in IDLE:
  - clear pick_valid_o, none_o, of_o, count, quiet count, fill-done latch, OF latch.
  - clause_o is held, but is not valid.
- DRAIN read handshake:
  - fifo_rden_o = (state==DRAIN) & ~fifo_empty_i, combinational.
  - A registered capture flag goes high the cycle after each read; fifo_clause_i is sampled on that cycle.
- On each capture:
  - n = count+1 (saturating at 2^CNT_W-1).
  - mask = 2^ceil(log2 n)-1, so mask = 0 for n=1.
  - Replace the candidate if (lfsr[CNT_W-1:0] & mask)==0. The first clause is always taken.
  - Set the candidate-valid flag.
- fill_done_i is latched sticky within a round; a pulse during DRAIN or coincident with start_i counts.
- Quiet counter:
  - Increments when the fill-done latch is set, fifo_empty_i=1, fifo_rden_o=0, and no capture is pending.
  - Clears on any read or capture, or on fifo_empty_i=0.
  - Saturates at SETTLE_CYCLES.
- fifo_of_i sampled high at any DRAIN cycle sets the OF latch.
- DONE cycle:
  - done_o=1.
  - If the OF latch is set: of_o=1, pick_valid_o=0, none_o=0, fifo_cof_o=1 for this cycle.
  - Otherwise, if count==0: none_o=1.
  - Otherwise: pick_valid_o=1 and clause_o = candidate.
- Reads never occur outside DRAIN.
- start_i in DRAIN or DONE is ignored.
- Reset mid-DRAIN aborts immediately. The tree OF is not cleared.

Optional Feature:
- Macro UNSAT_PICK_STATS_EN.
- When defined: adds output count_o [CNT_W], the number of clauses captured in the last round. It is registered at DONE, held until the next DONE, and reset to 0.
- When undefined: no port and no extra logic; behaviour otherwise identical.

Test Plan:
- Empty round: start_i, fill_done_i the next cycle, fifo_empty_i held 1 -> done_o exactly 1+SETTLE_CYCLES+1 cycles after fill_done_i (10 with default 8), none_o=1, pick_valid_o=0, fifo_rden_o never high.
- Single clause: tree presents 36'h0_0000_0ABC then empty, fill_done_i -> one fifo_rden_o pulse, pick_valid_o=1, clause_o=36'h0_0000_0ABC, none_o=0.
- Five clauses, LFSR_SEED=16'h0001: behavioural model with the same LFSR -> clause_o matches the model's pick; count_o=5 with UNSAT_PICK_STATS_EN.
- Overflow: fifo_of_i=1 during DRAIN with 3 clauses -> at DONE of_o=1, fifo_cof_o high exactly 1 cycle, pick_valid_o=0.
- Late arrival: fifo_empty_i drops to 0 after 5 quiet cycles -> quiet counter restarts, the clause is captured, done_o is not asserted before 8 further quiet cycles.
- Async reset asserted mid-DRAIN between clock edges -> fifo_rden_o=0 and busy_o=0 immediately, all outputs 0; a subsequent start_i runs a normal round.
